// File: rtl/quad_encoder_gen_pkg.sv
// Shared types and constants for the quadrature encoder generator.
// Phase table is common with the quadrature decoder.
package quad_pkg;

   localparam int COORD_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      DONE
   } state_t;

   // AB pattern for position[1:0]; A leads B when counting up
   localparam logic [1:0] QUAD_AB [4] = '{
      2'b00, 2'b10, 2'b11, 2'b01
   };

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Command handshake bundle for the encoder generator.
// Master issues a target coordinate, slave accepts it.
interface quad_encoder_gen_if
   import quad_pkg::*;
#(
   parameter int WIDTH = COORD_WIDTH
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_target;

   modport master (
      output cmd_valid,
      output cmd_target,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_target,
      output cmd_ready
   );

endinterface

// File: rtl/quad_step_timer.sv
// Reloadable down-counter pacing quarter-steps.
// tick fires when enabled and the count has reached zero.
module quad_step_timer #(
   parameter int PERIOD_CYCLES = 2
) (
   input  logic clock,
   input  logic a_reset,
   input  logic load,
   input  logic en,
   output logic tick
);

   localparam int TW =
      (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(PERIOD_CYCLES - 1);

   logic [TW-1:0] count;

   assign tick = en && (count == '0);

   // Load on command accept, reload after each tick, else count down
   always_ff @(posedge clock) begin
      if (!a_reset) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (en) begin
         if (count == '0) begin
            count <= RELOAD;
         end else begin
            count <= count - TW'(1);
         end
      end
   end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: walks position toward a
// commanded target one quarter-step per period, driving A/B.
module quad_encoder_gen
   import quad_pkg::*;
#(
   parameter int WIDTH         = COORD_WIDTH,
   parameter int PERIOD_CYCLES = 2
) (
   input  logic             clock,
   input  logic             a_reset,
   quad_encoder_gen_if.slave cmd,
   output logic             encoder_a,
   output logic             encoder_b,
   output logic [WIDTH-1:0] position,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pos_n;
   logic [WIDTH-1:0] stepped;
   logic             up;
   logic             ready;
   logic             accept;
   logic             load;
   logic             tick;

   assign cmd.cmd_ready = ready;
   assign accept  = cmd.cmd_valid && ready;
   assign load    = accept && (cmd.cmd_target != position);
   assign stepped = up ? position + WIDTH'(1)
                       : position - WIDTH'(1);

   quad_step_timer #(
      .PERIOD_CYCLES(PERIOD_CYCLES)
   ) u_timer (
      .clock  (clock),
      .a_reset(a_reset),
      .load   (load),
      .en     (state == MOVE),
      .tick   (tick)
   );

   // Next state and next position
   always_comb begin
      state_n = state;
      pos_n   = position;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_n = load ? MOVE : DONE;
            end
         end
         MOVE: begin
            if (tick) begin
               pos_n = stepped;
               if (stepped == target) begin
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, position and registered outputs
   always_ff @(posedge clock) begin
      if (!a_reset) begin
         state     <= IDLE;
         position  <= '0;
         encoder_a <= 1'b0;
         encoder_b <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ready     <= 1'b0;
      end else begin
         state    <= state_n;
         position <= pos_n;
         {encoder_a, encoder_b} <= QUAD_AB[pos_n[1:0]];
         busy     <= (state_n != IDLE);
         done     <= (state_n == DONE);
         ready    <= (state_n == IDLE);
      end
   end

   // Target and direction captured on accept
   always_ff @(posedge clock) begin
      if (!a_reset) begin
         target <= '0;
         up     <= 1'b0;
      end else if (accept) begin
         target <= cmd.cmd_target;
         up     <= (cmd.cmd_target > position);
      end
   end

endmodule
